uart_word_packer: RTL and testbench

Upstream feed stage for the BRAM FIFO on the UART receive path. It accepts one byte per strobe from the UART receiver and packs consecutive bytes into DATAW-bit words. It pushes each completed word into the FIFO write port (`data_in_a` / `w_en_a`) and honours the FIFO `full` flag. The UART cannot be stalled, so the block holds one completed word while the FIFO is full and reports a sticky overflow if a second word completes before the held word drains.

---
 rtl/uart_word_packer_if.sv | 28 ++
 rtl/uart_word_packer.sv | 96 +++++++++
 tb/tb_uart_word_packer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out bundle between the UART receiver, uart_word_packer and the BRAM FIFO write port.
// byte_valid is a one-cycle strobe and is never back-pressured; fifo_w_en writes fifo_data only while fifo_full is 0.
interface uart_word_packer_if #(
    parameter int DATAW = 32
);
    localparam int CNTW = $clog2(DATAW / 8);

    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             fifo_full;
    logic [DATAW-1:0] fifo_data;
    logic             fifo_w_en;
    logic             ovf_clr;
    logic             overflow;
    logic [CNTW-1:0]  byte_cnt;
    logic             hold_valid;

    // master drives bytes and FIFO status; slave is the packer
    modport master (
        output byte_in, byte_valid, fifo_full, ovf_clr,
        input  fifo_data, fifo_w_en, overflow, byte_cnt, hold_valid
    );

    modport slave (
        input  byte_in, byte_valid, fifo_full, ovf_clr,
        output fifo_data, fifo_w_en, overflow, byte_cnt, hold_valid
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes into DATAW-bit words and feeds them to the FIFO through a one-word hold register.
// Define UART_WORD_PACKER_BIG_ENDIAN_EN to place the first byte in the most significant lane.
module uart_word_packer #(
    parameter int DATAW = 32
) (
    input  logic              clk,
    input  logic              rst,
    uart_word_packer_if.slave bus
);
    localparam int BYTES = DATAW / 8;
    localparam int CNTW  = $clog2(BYTES);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BYTES - 1);

    logic [DATAW-1:0] asm_q, asm_d;
    logic [DATAW-1:0] hold_q, hold_d;
    logic [DATAW-1:0] word_merged;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  lane;
    logic             hold_valid_q, hold_valid_d;
    logic             ovf_q, ovf_d;
    logic             word_done;
    logic             wr_en;
    logic             load;
    logic             drop;

`ifdef UART_WORD_PACKER_BIG_ENDIAN_EN
    assign lane = LAST_CNT - cnt_q;
`else
    assign lane = cnt_q;
`endif

    // Assembly word with the incoming byte merged into its lane.
    always_comb begin
        word_merged = asm_q;
        for (int k = 0; k < BYTES; k++) begin
            if (lane == CNTW'(k)) begin
                word_merged[8*k +: 8] = bus.byte_in;
            end
        end
    end

    // No write may leave during the reset cycle, even if a word was held.
    assign wr_en     = hold_valid_q & ~bus.fifo_full & ~rst;
    assign word_done = bus.byte_valid & (cnt_q == LAST_CNT);
    assign load      = word_done & (~hold_valid_q | wr_en);
    assign drop      = word_done & hold_valid_q & ~wr_en;

    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        ovf_d        = ovf_q;

        if (bus.byte_valid) begin
            asm_d = word_merged;
            cnt_d = word_done ? '0 : cnt_q + 1'b1;
        end

        if (load) begin
            hold_d       = word_merged;
            hold_valid_d = 1'b1;
        end else if (wr_en) begin
            hold_valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.fifo_data  = hold_q;
    assign bus.fifo_w_en  = wr_en;
    assign bus.overflow   = ovf_q;
    assign bus.byte_cnt   = cnt_q;
    assign bus.hold_valid = hold_valid_q;
endmodule

// File: tb/tb_uart_word_packer.sv
// Directed and randomized checks of uart_word_packer against a byte-queue reference model.
module tb_uart_word_packer;
    localparam int DATAW = 32;
    localparam int BYTES = DATAW / 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_word_packer_if #(.DATAW(DATAW)) bus ();

    uart_word_packer #(.DATAW(DATAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bytes of the partial word, the hold register, overflow flag.
    logic [7:0]       m_bytes[$];
    logic [DATAW-1:0] m_hold   = '0;
    bit               m_hold_v = 1'b0;
    bit               m_ovf    = 1'b0;
    logic [DATAW-1:0] exp_q[$];
    logic [DATAW-1:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
`ifdef UART_WORD_PACKER_BIG_ENDIAN_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic cycle(input bit bv, input logic [7:0] b, input bit full, input bit clr, input bit r);
        logic [DATAW-1:0] w;
        logic [DATAW-1:0] exp_w;
        bit exp_wen;
        bit loaded;
        bit dropped;
        @(negedge clk);
        rst            = r;
        bus.byte_valid = bv;
        bus.byte_in    = b;
        bus.fifo_full  = full;
        bus.ovf_clr    = clr;
        #1;
        exp_wen = m_hold_v && !full && !r;
        chk("w_en", 64'(bus.fifo_w_en), 64'(exp_wen));
        chk("fifo_data", 64'(bus.fifo_data), 64'(m_hold));
        chk("hold_valid", 64'(bus.hold_valid), 64'(m_hold_v));
        chk("byte_cnt", 64'(bus.byte_cnt), 64'(m_bytes.size()));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        if (bus.fifo_w_en === 1'b1) begin
            got_q.push_back(bus.fifo_data);
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("sb_word", 64'(bus.fifo_data), 64'(exp_w));
        end
        if (r) begin
            m_bytes.delete();
            exp_q.delete();
            m_hold   = '0;
            m_hold_v = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            loaded  = 1'b0;
            dropped = 1'b0;
            if (bv) begin
                m_bytes.push_back(b);
                if (m_bytes.size() == BYTES) begin
                    w = '0;
                    for (int i = 0; i < BYTES; i++) begin
`ifdef UART_WORD_PACKER_BIG_ENDIAN_EN
                        w = w | (DATAW'(m_bytes[i]) << (8 * (BYTES - 1 - i)));
`else
                        w = w | (DATAW'(m_bytes[i]) << (8 * i));
`endif
                    end
                    m_bytes.delete();
                    if (!m_hold_v || exp_wen) begin
                        m_hold   = w;
                        m_hold_v = 1'b1;
                        loaded   = 1'b1;
                        exp_q.push_back(w);
                    end else begin
                        dropped = 1'b1;
                    end
                end
            end
            if (exp_wen && !loaded) m_hold_v = 1'b0;
            if (dropped) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    endtask

    task automatic idle(input int n, input bit full);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, full, 1'b0, 1'b0);
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input bit full);
        cycle(1'b1, b0, full, 1'b0, 1'b0);
        cycle(1'b1, b1, full, 1'b0, 1'b0);
        cycle(1'b1, b2, full, 1'b0, 1'b0);
        cycle(1'b1, b3, full, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        bus.fifo_full  = 1'b0;
        bus.ovf_clr    = 1'b0;

        // Reset state
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_data", 64'(bus.fifo_data), 64'd0);
        chk("rst_wen", 64'(bus.fifo_w_en), 64'd0);

        // Single word, one write one cycle after the last byte
        got_q.delete();
        send4(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        chk("t1_wen_next", 64'(bus.fifo_w_en), 64'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t1_count", 64'(got_q.size()), 64'd1);
        chk("t1_word", 64'(got_q[0]), 64'(word4(8'h11, 8'h22, 8'h33, 8'h44)));
        chk("t1_ovf", 64'(bus.overflow), 64'd0);

        // Back-to-back stream of two words
        got_q.delete();
        send4(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        send4(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
        idle(2, 1'b0);
        chk("t2_count", 64'(got_q.size()), 64'd2);
        chk("t2_word0", 64'(got_q[0]), 64'(word4(8'h01, 8'h02, 8'h03, 8'h04)));
        chk("t2_word1", 64'(got_q[1]), 64'(word4(8'h05, 8'h06, 8'h07, 8'h08)));
        chk("t2_cnt", 64'(bus.byte_cnt), 64'd0);

        // Backpressure: held while full, one write after release
        got_q.delete();
        send4(8'h21, 8'h22, 8'h23, 8'h24, 1'b1);
        idle(5, 1'b1);
        chk("t3_held", 64'(bus.hold_valid), 64'd1);
        chk("t3_nowrite", 64'(got_q.size()), 64'd0);
        idle(3, 1'b0);
        chk("t3_count", 64'(got_q.size()), 64'd1);
        chk("t3_word", 64'(got_q[0]), 64'(word4(8'h21, 8'h22, 8'h23, 8'h24)));
        chk("t3_hv", 64'(bus.hold_valid), 64'd0);

        // Overflow: second word dropped while full
        got_q.delete();
        send4(8'h31, 8'h32, 8'h33, 8'h34, 1'b1);
        send4(8'h35, 8'h36, 8'h37, 8'h38, 1'b1);
        idle(1, 1'b1);
        chk("t4_ovf", 64'(bus.overflow), 64'd1);
        idle(3, 1'b0);
        chk("t4_count", 64'(got_q.size()), 64'd1);
        chk("t4_word", 64'(got_q[0]), 64'(word4(8'h31, 8'h32, 8'h33, 8'h34)));
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t4_ovf_hold", 64'(bus.overflow), 64'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t4_ovf_clr", 64'(bus.overflow), 64'd0);

        // Drain and load in the same cycle
        got_q.delete();
        send4(8'h41, 8'h42, 8'h43, 8'h44, 1'b1);
        cycle(1'b1, 8'h51, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h52, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h53, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h54, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_hv", 64'(bus.hold_valid), 64'd1);
        chk("t5_ovf", 64'(bus.overflow), 64'd0);
        idle(3, 1'b0);
        chk("t5_count", 64'(got_q.size()), 64'd2);
        chk("t5_old", 64'(got_q[0]), 64'(word4(8'h41, 8'h42, 8'h43, 8'h44)));
        chk("t5_new", 64'(got_q[1]), 64'(word4(8'h51, 8'h52, 8'h53, 8'h54)));

        // Reset mid-word, and reset while a word is held
        got_q.delete();
        send4(8'h61, 8'h62, 8'h63, 8'h64, 1'b1);
        cycle(1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h72, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send4(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0);
        idle(2, 1'b0);
        chk("t6_count", 64'(got_q.size()), 64'd1);
        chk("t6_word", 64'(got_q[0]), 64'(word4(8'hA0, 8'hA1, 8'hA2, 8'hA3)));

        // Randomized traffic with bursts of backpressure
        begin
            bit full_r = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 9) == 0) full_r = ~full_r;
                cycle($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)), full_r,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
            end
        end
        idle(4, 1'b0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
